// File: rtl/accum_issue_ctrl.sv
// Accumulator issue sequencer: registered beats (latency 1); in_ready drops on read-after-write hazards, never holds o_valid.
// `define ACCUM_ISSUE_CTRL_PERF_EN adds the saturating stall_cnt output. HAZ_GAP must be >= 2.
module accum_issue_ctrl #(
    parameter int DATAW   = 32,
    parameter int DEPTH   = 512,
    parameter int ADDRW   = 9,
    parameter int SUBW    = 8,
    parameter int HAZ_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ADDRW:0]   cfg_len,
    input  logic [SUBW-1:0]  cfg_nsub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    output logic [ADDRW-1:0] o_addr,
    output logic             o_accum,
    output logic             o_last,
    output logic             busy,
    output logic             done
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int WIN = HAZ_GAP - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state, state_nxt;
    logic [ADDRW:0]              len_r;
    logic [SUBW-1:0]             nsub_r;
    logic [ADDRW-1:0]            addr_cnt;
    logic [SUBW-1:0]             sub_cnt;
    logic [WIN-1:0]              win_vld;
    logic [WIN-1:0][ADDRW-1:0]   win_addr;

    logic cand_accum, cand_last, addr_wrap, win_hit, hazard;
    logic in_fire, cfg_fire, final_beat;

    always_comb begin
        cand_accum = (sub_cnt != '0);
        cand_last  = (sub_cnt == nsub_r - SUBW'(1));
        addr_wrap  = ({1'b0, addr_cnt} == len_r - (ADDRW+1)'(1));
        final_beat = addr_wrap && cand_last;

        win_hit = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (win_vld[i] && (win_addr[i] == addr_cnt)) win_hit = 1'b1;
        end
        // First subset overwrites rather than reads, so it never waits on the window.
        hazard = cand_accum && win_hit;

        cfg_ready = (state == IDLE);
        busy      = (state == RUN);
        in_ready  = (state == RUN) && !hazard;
        in_fire   = in_valid && in_ready;
        cfg_fire  = cfg_valid && cfg_ready;

        state_nxt = state;
        case (state)
            IDLE:    if (cfg_fire) state_nxt = RUN;
            RUN:     if (in_fire && final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_r    <= '0;
            nsub_r   <= '0;
            addr_cnt <= '0;
            sub_cnt  <= '0;
            win_vld  <= '0;
            win_addr <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_addr   <= '0;
            o_accum  <= 1'b0;
            o_last   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;

            // Window keeps shifting in every state so it drains across vectors.
            for (int i = WIN - 1; i > 0; i--) begin
                win_vld[i]  <= win_vld[i-1];
                win_addr[i] <= win_addr[i-1];
            end
            win_vld[0]  <= in_fire;
            win_addr[0] <= addr_cnt;

            if (cfg_fire) begin
                len_r    <= (cfg_len == '0) ? (ADDRW+1)'(DEPTH) : cfg_len;
                nsub_r   <= (cfg_nsub == '0) ? SUBW'(1) : cfg_nsub;
                addr_cnt <= '0;
                sub_cnt  <= '0;
            end

            if (in_fire) begin
                addr_cnt <= addr_wrap ? '0 : addr_cnt + ADDRW'(1);
                if (addr_wrap) sub_cnt <= sub_cnt + SUBW'(1);
                o_data   <= in_data;
                o_addr   <= addr_cnt;
                o_accum  <= cand_accum;
                o_last   <= cand_last;
            end

            o_valid <= in_fire;
            done    <= in_fire && final_beat;
        end
    end

`ifdef ACCUM_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || cfg_fire) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_issue_ctrl.sv
// Randomized bench for accum_issue_ctrl with a per-cycle behavioural reference model and directed literal checks.
module tb_accum_issue_ctrl;
    localparam int DATAW = 32, DEPTH = 512, ADDRW = 9, SUBW = 8, HAZ_GAP = 4;

    logic             clk = 1'b0;
    logic             rst, cfg_valid, cfg_ready, in_valid, in_ready;
    logic [ADDRW:0]   cfg_len;
    logic [SUBW-1:0]  cfg_nsub;
    logic [DATAW-1:0] in_data, o_data;
    logic             o_valid, o_accum, o_last, busy, done;
    logic [ADDRW-1:0] o_addr;
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    accum_issue_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .SUBW(SUBW), .HAZ_GAP(HAZ_GAP)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_len(cfg_len), .cfg_nsub(cfg_nsub), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr),
        .o_accum(o_accum), .o_last(o_last), .busy(busy), .done(done)
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { int cyc; int addr; bit accum; bit last; bit dn; } beat_t;
    beat_t beats[$];
    int    done_seen = 0;

    // Reference model: vector position k, per-address time of last issue.
    int  cyc = 0;
    bit  m_run = 0;
    int  m_len = 0, m_nsub = 0, m_k = 0, m_stall = 0;
    int  last_issue[DEPTH];
    bit  e_ov = 0, e_done = 0, e_zero = 1, e_accum_r = 0, e_last_r = 0;
    int  e_addr_r = 0;
    logic [DATAW-1:0] e_data_r = '0;

    initial begin
        int e_addr, e_sub, e_haz, e_ir;
        bit e_accum, hs_in, fin;
        for (int i = 0; i < DEPTH; i++) last_issue[i] = -1000;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            e_addr  = (m_len > 0) ? m_k % m_len : 0;
            e_sub   = (m_len > 0) ? m_k / m_len : 0;
            e_accum = (e_sub != 0);
            e_haz   = m_run && e_accum && (cyc - last_issue[e_addr] < HAZ_GAP);
            e_ir    = m_run && !e_haz;

            chk("cfg_ready", cfg_ready, !m_run);
            chk("in_ready", in_ready, e_ir);
            chk("busy", busy, m_run);
            chk("o_valid", o_valid, e_ov);
            chk("done", done, e_done);
            if (e_ov || e_zero) begin
                chk("o_data", o_data, e_data_r);
                chk("o_addr", o_addr, e_addr_r);
                chk("o_accum", o_accum, e_accum_r);
                chk("o_last", o_last, e_last_r);
            end
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
            if (o_valid === 1'b1) beats.push_back('{cyc, int'(o_addr), o_accum, o_last, done});
            if (done === 1'b1) done_seen++;

            if (rst) begin
                m_run = 0; m_len = 0; m_nsub = 0; m_k = 0; m_stall = 0;
                e_ov = 0; e_done = 0; e_zero = 1;
                e_data_r = '0; e_addr_r = 0; e_accum_r = 0; e_last_r = 0;
                for (int i = 0; i < DEPTH; i++) last_issue[i] = -1000;
            end else begin
                hs_in = in_valid && e_ir;
                if (m_run && in_valid && e_haz) m_stall++;
                e_ov = hs_in; e_done = 0;
                if (hs_in) begin
                    fin = (m_k == m_len * m_nsub - 1);
                    e_zero = 0; e_data_r = in_data; e_addr_r = e_addr;
                    e_accum_r = e_accum; e_last_r = (e_sub == m_nsub - 1);
                    e_done = fin;
                    last_issue[e_addr] = cyc;
                    m_k++;
                    if (fin) m_run = 0;
                end else if (!m_run && cfg_valid) begin
                    m_len  = (cfg_len == 0) ? DEPTH : int'(cfg_len);
                    m_nsub = (cfg_nsub == 0) ? 1 : int'(cfg_nsub);
                    m_k = 0; m_stall = 0; m_run = 1;
                end
            end
        end
    end

    // Drives one vector; abort_at>0 pulses reset once that many beats are out.
    task automatic run_vec(input int len, input int nsub, input int mode, input int abort_at);
        int d0, n, budget, t;
        beats.delete();
        d0 = done_seen;
        cfg_len = len[ADDRW:0]; cfg_nsub = nsub[SUBW-1:0]; cfg_valid = 1'b1; in_valid = 1'b0;
        t = 0;
        while (cfg_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        chk("cfg_accept", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        budget = ((len == 0) ? DEPTH : len) * ((nsub == 0) ? 1 : nsub) * HAZ_GAP * 4 + 50;
        n = 0;
        while (done_seen == d0 && n < budget) begin
            if (abort_at > 0 && beats.size() >= abort_at) break;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((n % 5) == 0) || ((n % 5) == 2) || ((n % 5) == 3);
                default: in_valid = ($urandom_range(0, 9) < 7);
            endcase
            in_data = $urandom;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (abort_at > 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("mid_rst_o_valid", o_valid, 0);
            chk("mid_rst_cfg_ready", cfg_ready, 1);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_o_addr", o_addr, 0);
            chk("mid_rst_o_data", o_data, 0);
        end else begin
            chk("vec_done", done_seen > d0, 1);
        end
    endtask

    int exp_rel[6] = '{0, 1, 4, 5, 8, 9};

    initial begin
        int bad;
        rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_nsub = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        run_vec(8, 3, 0, 0);
        chk("basic_count", beats.size(), 24);
        if (beats.size() == 24) begin
            bad = 0;
            for (int i = 0; i < 24; i++)
                if (beats[i].addr != i % 8 || beats[i].accum != (i >= 8) || beats[i].last != (i >= 16) ||
                    beats[i].dn != (i == 23)) bad++;
            chk("basic_fields_bad", bad, 0);
            chk("basic_span", beats[23].cyc - beats[0].cyc, 23);
        end
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
        chk("basic_stalls", stall_cnt, 0);
`endif

        run_vec(2, 3, 0, 0);
        chk("short_count", beats.size(), 6);
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            chk("short_rel_cyc", beats[i].cyc - beats[0].cyc, exp_rel[i]);
            chk("short_addr", beats[i].addr, i % 2);
        end
`ifdef ACCUM_ISSUE_CTRL_PERF_EN
        chk("short_stalls", stall_cnt, 4);
`endif

        run_vec(1, 4, 0, 0);
        chk("single_count", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            chk("single_rel_cyc", beats[i].cyc - beats[0].cyc, 4 * i);
            chk("single_accum", beats[i].accum, i != 0);
            chk("single_last", beats[i].last, i == 3);
            chk("single_done", beats[i].dn, i == 3);
        end

        run_vec(0, 0, 0, 0);
        chk("zsub_count", beats.size(), 512);
        bad = 0;
        foreach (beats[i]) if (beats[i].addr != i || beats[i].accum || !beats[i].last) bad++;
        chk("zsub_fields_bad", bad, 0);
        if (beats.size() > 0) chk("zsub_done_addr", beats[beats.size()-1].dn ? beats[beats.size()-1].addr : -1, 511);

        run_vec(4, 2, 1, 0);
        chk("bubble_count", beats.size(), 8);
        bad = 0;
        foreach (beats[i]) if (beats[i].addr != i % 4 || beats[i].accum != (i >= 4) || beats[i].last != (i >= 4)) bad++;
        chk("bubble_fields_bad", bad, 0);

        run_vec(8, 2, 0, 10);
        run_vec(3, 1, 0, 0);
        chk("post_rst_count", beats.size(), 3);
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            chk("post_rst_addr", beats[i].addr, i);
            chk("post_rst_accum", beats[i].accum, 0);
            chk("post_rst_last", beats[i].last, 1);
        end

        for (int v = 0; v < 16; v++)
            run_vec($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 10), $urandom_range(0, 5),
                    $urandom_range(0, 2), 0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accum_issue_ctrl.md
Name: accum_issue_ctrl

Overview:
- Upstream-side sequencer for the accumulator block.
- Takes a per-vector config (entries per subset, number of subsets) and a valid/ready stream of DPE partial sums.
- Emits the accumulator's input beats: valid, data, address, accum flag and last flag.
- Enforces the accumulator's read-after-write spacing, stalling upstream whenever an address would be re-read before its previous update has been written back.

Parameters:
- DATAW, 32, partial-sum data width.
- DEPTH, 512, accumulator memory depth (maximum entries per subset).
- ADDRW, 9, address width, equal to clog2(DEPTH).
- SUBW, 8, width of the subset counter.
- HAZ_GAP, 4, minimum cycle spacing between two beats to the same address when the second has o_accum=1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cfg_valid  input  1  config offered
- cfg_ready  output  1  config accepted when both cfg_valid and cfg_ready are high
- cfg_len  input  ADDRW+1  entries per subset; 0 means DEPTH
- cfg_nsub  input  SUBW  subsets per vector; 0 means 1
- in_valid  input  1  partial sum offered
- in_ready  output  1  partial sum accepted when both in_valid and in_ready are high
- in_data  input  DATAW  partial sum
- o_valid  output  1  beat to accumulator (drives its i_valid)
- o_data  output  DATAW  drives i_data
- o_addr  output  ADDRW  drives i_addr
- o_accum  output  1  drives i_accum
- o_last  output  1  drives i_last
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on the final beat of a vector

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0, except cfg_ready=1. State returns to IDLE. Counters and hazard window are cleared.
- FSM has two states, IDLE and RUN.
  - IDLE: cfg_ready=1, in_ready=0. A cfg handshake latches len and nsub (with the 0-substitution rules), clears addr_cnt and sub_cnt, and moves to RUN.
  - RUN: cfg_ready=0.
- Candidate beat fields:
  - addr = addr_cnt
  - accum = (sub_cnt != 0)
  - last = (sub_cnt == nsub-1)
- Hazard:
  - The window holds (valid, addr) for beats issued in the previous HAZ_GAP-1 cycles.
  - hazard = accum && any valid window entry equals addr_cnt.
- in_ready = RUN && !hazard. This is combinational from registered state only; it has no path from in_valid.
- On an input handshake:
  - The next cycle shows o_valid=1 with o_data=in_data and o_addr/o_accum/o_last = candidate values (registered outputs, latency 1).
  - addr_cnt increments. At len-1 it wraps to 0 and sub_cnt increments.
- No handshake in a cycle: o_valid=0 next cycle. The window still shifts, inserting an invalid entry.
- Final beat (addr_cnt=len-1 and sub_cnt=nsub-1):
  - done=1 in the same cycle as that beat's o_valid.
  - FSM returns to IDLE. The window keeps draining.
- cfg may be accepted the cycle after the final beat. The next vector's first subset has accum=0, so the first subset is never stalled by the window. Later subsets are checked normally.
- len=1 with nsub>1: beats issue every HAZ_GAP cycles.
- len>=HAZ_GAP: continuous streaming with no stalls.
- The accumulator has no backpressure, so o_valid is never held.
- Reset mid-vector discards all progress. Beats already issued are not recalled.

Optional Feature:
- Macro: ACCUM_ISSUE_CTRL_PERF_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - It counts cycles in RUN with in_valid=1 and hazard=1.
  - It saturates at all-ones, clears on rst, and clears on cfg handshake.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic streaming: len=8, nsub=3, in_valid held high.
  - Expect 24 consecutive beats with addr 0..7 repeated three times.
  - o_accum=0 on beats 1-8 and 1 after; o_last=1 on beats 17-24.
  - done on beat 24; zero stalls (stall_cnt=0).
- Short subset: len=2, nsub=3, HAZ_GAP=4, continuous input.
  - Beats at relative cycles 0,1,4,5,8,9 with addrs 0,1,0,1,0,1.
  - stall_cnt=4.
- Single entry: len=1, nsub=4.
  - Beats every 4th cycle to addr 0, with accum 0,1,1,1 and last only on the 4th.
  - done with the 4th beat.
- Zero-substitution config: cfg_len=0, cfg_nsub=0.
  - Expect 512 beats with addr 0..511, all accum=0 and all last=1.
  - done on addr 511.
- Upstream bubbles: len=4, nsub=2, in_valid pattern 1,0,1,1,0,...
  - Beat order and field values match the continuous case.
  - in_data is passed through unmodified.
- Reset mid-vector: assert rst during subset 1 of a len=8, nsub=2 vector.
  - Outputs are 0 and cfg_ready=1 the next cycle.
  - A new cfg of len=3, nsub=1 yields addr 0,1,2 with accum=0 and last=1.
